grid_store: RTL and testbench

//  Parametrised game-grid memory for the snake playfield: holds one CODE_W-bit cell code per tile.

---
 rtl/grid_store.sv | 257 +++++++++++++++++++++++++
 tb/tb_grid_store.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/grid_store.sv
// rtl/grid_store.sv - snake playfield cell memory with init sweep, logic ports and VGA tile overlay
// Holds one code per tile; overlays tile colours on the background pixel stream.
module grid_store #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int CELL_LOG2 = 5,
  parameter int CODE_W    = 4,
  parameter int SNACK_X   = 2,
  parameter int SNACK_Y   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       vcount_in,
  input  logic [15:0]       hcount_in,
  input  logic              vsync_in,
  input  logic              hsync_in,
  input  logic [11:0]       rgb_in,
  output logic [15:0]       vcount_out,
  output logic [15:0]       hcount_out,
  output logic              vsync_out,
  output logic              hsync_out,
  output logic [11:0]       rgb_out,
  input  logic              wr_en,
  input  logic [15:0]       wr_x,
  input  logic [15:0]       wr_y,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ack,
  input  logic              rd_en,
  input  logic [15:0]       rd_x,
  input  logic [15:0]       rd_y,
  output logic [CODE_W-1:0] rd_code,
  output logic              rd_valid,
  input  logic              clear_req,
  output logic              init_busy
);

  localparam int DEPTH = GRID_W * GRID_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0]     LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]     ROW_LEN  = AW'(GRID_W);
  localparam logic [15:0]       GW16     = 16'(GRID_W);
  localparam logic [15:0]       GH16     = 16'(GRID_H);
  localparam logic [15:0]       GW_LAST  = 16'(GRID_W - 1);
  localparam logic [15:0]       GH_LAST  = 16'(GRID_H - 1);
  localparam logic [15:0]       SX16     = 16'(SNACK_X);
  localparam logic [15:0]       SY16     = 16'(SNACK_Y);

  localparam logic [CODE_W-1:0] C_NULL  = '0;
  localparam logic [CODE_W-1:0] C_SNAKE = CODE_W'(1);
  localparam logic [CODE_W-1:0] C_ROCK  = CODE_W'(2);
  localparam logic [CODE_W-1:0] C_SNACK = CODE_W'(4);

  localparam logic [11:0] RGB_SNAKE = 12'h0F0;
  localparam logic [11:0] RGB_ROCK  = 12'h222;
  localparam logic [11:0] RGB_SNACK = 12'hF00;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [15:0]         ix_q, ix_d;
  logic [15:0]         iy_q, iy_d;

  logic [CODE_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [CODE_W-1:0]   mem_wdata;
  logic [CODE_W-1:0]   init_code;

  logic                wr_in_range, wr_accept;
  logic [AW-1:0]       wr_addr;
  logic                wr_ack_q, wr_ack_d;

  logic                rd_in_range;
  logic [AW-1:0]       rd_addr;
  logic [CODE_W-1:0]   rd_code_q, rd_code_d;
  logic                rd_valid_q, rd_valid_d;

  logic [15:0]         tx_q, tx_d;
  logic [15:0]         ty_q, ty_d;
  logic                in_grid_q, in_grid_d;
  logic [15:0]         vcount1_q, hcount1_q;
  logic                vsync1_q, hsync1_q;
  logic [11:0]         rgb1_q;
  logic [AW-1:0]       pix_addr;
  logic [CODE_W-1:0]   pix_code;

  logic [15:0]         vcount2_q, hcount2_q;
  logic                vsync2_q, hsync2_q;
  logic [11:0]         rgb2_q, rgb2_d;

  // Border tiles are rocks; one seeded snack; everything else empty.
  always_comb begin
    init_code = C_NULL;
    if (ix_q == 16'd0 || ix_q == GW_LAST || iy_q == 16'd0 || iy_q == GH_LAST) begin
      init_code = C_ROCK;
    end else if (ix_q == SX16 && iy_q == SY16) begin
      init_code = C_SNACK;
    end
  end

  assign wr_in_range = (wr_x < GW16) && (wr_y < GH16);
  assign wr_accept   = (state_q == ST_READY) && wr_en && wr_in_range;
  assign wr_addr     = AW'(wr_y) * ROW_LEN + AW'(wr_x);

  assign rd_in_range = (rd_x < GW16) && (rd_y < GH16);
  assign rd_addr     = AW'(rd_y) * ROW_LEN + AW'(rd_x);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ix_d      = ix_q;
    iy_d      = iy_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = init_code;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = init_code;
        if (idx_q == LAST_IDX) begin
          state_d = ST_READY;
          idx_d   = '0;
          ix_d    = '0;
          iy_d    = '0;
        end else begin
          idx_d = idx_q + AW'(1);
          if (ix_q == GW_LAST) begin
            ix_d = '0;
            iy_d = iy_q + 16'd1;
          end else begin
            ix_d = ix_q + 16'd1;
          end
        end
      end
      ST_READY: begin
        if (wr_accept) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_code;
        end
        // The logic write above is still committed in the clear cycle.
        if (clear_req) begin
          state_d = ST_INIT;
          idx_d   = '0;
          ix_d    = '0;
          iy_d    = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
        ix_d    = '0;
        iy_d    = '0;
      end
    endcase
  end

  always_comb begin
    wr_ack_d   = wr_accept;
    rd_valid_d = rd_en;
    rd_code_d  = rd_code_q;
    if (rd_en) begin
      rd_code_d = (state_q == ST_READY && rd_in_range) ? mem_q[rd_addr] : C_ROCK;
    end
  end

  always_comb begin
    tx_d      = hcount_in >> CELL_LOG2;
    ty_d      = vcount_in >> CELL_LOG2;
    in_grid_d = (tx_d < GW16) && (ty_d < GH16);
  end

  assign pix_addr = AW'(ty_q) * ROW_LEN + AW'(tx_q);
  assign pix_code = in_grid_q ? mem_q[pix_addr] : C_NULL;

  always_comb begin
    rgb2_d = rgb1_q;
    if (in_grid_q && state_q == ST_READY) begin
      case (pix_code)
        C_SNAKE: rgb2_d = RGB_SNAKE;
        C_ROCK:  rgb2_d = RGB_ROCK;
        C_SNACK: rgb2_d = RGB_SNACK;
        default: rgb2_d = rgb1_q;
      endcase
    end
  end

  // Cell storage is not reset; the init sweep rewrites every tile.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      idx_q      <= '0;
      ix_q       <= '0;
      iy_q       <= '0;
      wr_ack_q   <= 1'b0;
      rd_code_q  <= '0;
      rd_valid_q <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      in_grid_q  <= 1'b0;
      vcount1_q  <= '0;
      hcount1_q  <= '0;
      vsync1_q   <= 1'b0;
      hsync1_q   <= 1'b0;
      rgb1_q     <= '0;
      vcount2_q  <= '0;
      hcount2_q  <= '0;
      vsync2_q   <= 1'b0;
      hsync2_q   <= 1'b0;
      rgb2_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      wr_ack_q   <= wr_ack_d;
      rd_code_q  <= rd_code_d;
      rd_valid_q <= rd_valid_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      in_grid_q  <= in_grid_d;
      vcount1_q  <= vcount_in;
      hcount1_q  <= hcount_in;
      vsync1_q   <= vsync_in;
      hsync1_q   <= hsync_in;
      rgb1_q     <= rgb_in;
      vcount2_q  <= vcount1_q;
      hcount2_q  <= hcount1_q;
      vsync2_q   <= vsync1_q;
      hsync2_q   <= hsync1_q;
      rgb2_q     <= rgb2_d;
    end
  end

  assign vcount_out = vcount2_q;
  assign hcount_out = hcount2_q;
  assign vsync_out  = vsync2_q;
  assign hsync_out  = hsync2_q;
  assign rgb_out    = rgb2_q;
  assign wr_ack     = wr_ack_q;
  assign rd_code    = rd_code_q;
  assign rd_valid   = rd_valid_q;
  assign init_busy  = (state_q == ST_INIT);

endmodule

// File: tb/tb_grid_store.sv
// tb/tb_grid_store.sv - directed self-checking bench for grid_store
// Inputs change and outputs are sampled on the falling clock edge.
module tb_grid_store;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, hsync_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [15:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out;
  logic [11:0] rgb_out;
  logic        wr_en = 1'b0;
  logic [15:0] wr_x = '0, wr_y = '0;
  logic [3:0]  wr_code = '0;
  logic        wr_ack;
  logic        rd_en = 1'b0;
  logic [15:0] rd_x = '0, rd_y = '0;
  logic [3:0]  rd_code;
  logic        rd_valid;
  logic        clear_req = 1'b0;
  logic        init_busy;

  int checks   = 0;
  int failures = 0;

  grid_store dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .rgb_in(rgb_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .rgb_out(rgb_out),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_code(wr_code), .wr_ack(wr_ack),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_code(rd_code), .rd_valid(rd_valid),
    .clear_req(clear_req), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] exp);
    rd_en = 1'b1; rd_x = x; rd_y = y;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_code), 32'(exp));
  endtask

  task automatic do_write(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [3:0] code, input logic exp_ack);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_code = code;
    @(negedge clk);
    wr_en = 1'b0;
    chk(tag, 32'(wr_ack), 32'(exp_ack));
  endtask

  task automatic pixel(input string tag, input logic [15:0] h, input logic [15:0] v,
                       input logic [11:0] rgb, input logic [11:0] exp);
    hcount_in = h; vcount_in = v; rgb_in = rgb;
    repeat (2) @(negedge clk);
    chk(tag, 32'(rgb_out), 32'(exp));
  endtask

  // Counts busy-high samples; start carries samples already taken by the caller.
  task automatic wait_sweep(input string tag, input int start);
    int hi;
    hi = start;
    while (init_busy && hi < 2000) begin
      hi++;
      @(negedge clk);
    end
    chk(tag, 32'(hi), 32'd768);
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_code", 32'(rd_code), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_rgb_out", 32'(rgb_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("init_sweep_len", 0);
    do_read("rd_0_0", 16'd0, 16'd0, 4'd2);
    do_read("rd_31_23", 16'd31, 16'd23, 4'd2);
    do_read("rd_2_2", 16'd2, 16'd2, 4'd4);
    do_read("rd_5_5", 16'd5, 16'd5, 4'd0);

    do_write("wr_10_7_ack", 16'd10, 16'd7, 4'd1, 1'b1);
    do_read("rd_10_7", 16'd10, 16'd7, 4'd1);
    hsync_in = 1'b1; vsync_in = 1'b1;
    pixel("pix_snake", 16'd323, 16'd224, 12'hABC, 12'h0F0);
    chk("hcount_delay", 32'(hcount_out), 32'd323);
    chk("vcount_delay", 32'(vcount_out), 32'd224);
    chk("hsync_delay", 32'(hsync_out), 32'd1);
    chk("vsync_delay", 32'(vsync_out), 32'd1);
    hsync_in = 1'b0; vsync_in = 1'b0;
    pixel("pix_null", 16'd160, 16'd160, 12'h123, 12'h123);
    pixel("pix_rock", 16'd3, 16'd5, 12'h456, 12'h222);
    pixel("pix_snack", 16'd64, 16'd95, 12'h789, 12'hF00);
    pixel("pix_outside", 16'd1100, 16'd100, 12'h3C3, 12'h3C3);

    do_read("rd_oob_x", 16'd32, 16'd0, 4'd2);
    do_read("rd_oob_y", 16'd0, 16'd24, 4'd2);
    do_read("rd_oob_max", 16'hFFFF, 16'hFFFF, 4'd2);
    do_write("wr_oob_noack", 16'd40, 16'd3, 4'd1, 1'b0);
    do_read("rd_alias_8_4", 16'd8, 16'd4, 4'd0);

    wr_en = 1'b1; wr_x = 16'd6; wr_y = 16'd6; wr_code = 4'd1;
    rd_en = 1'b1; rd_x = 16'd6; rd_y = 16'd6;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rbw_old", 32'(rd_code), 32'd0);
    chk("rbw_ack", 32'(wr_ack), 32'd1);
    do_read("rbw_new", 16'd6, 16'd6, 4'd1);

    clear_req = 1'b1;
    wr_en = 1'b1; wr_x = 16'd12; wr_y = 16'd12; wr_code = 4'd1;
    @(negedge clk);
    clear_req = 1'b0; wr_en = 1'b0;
    chk("clr_wr_served", 32'(wr_ack), 32'd1);
    chk("clr_busy", 32'(init_busy), 32'd1);
    do_write("sweep_wr_noack", 16'd3, 16'd3, 4'd1, 1'b0);
    do_read("sweep_rd_rock", 16'd5, 16'd5, 4'd2);
    wait_sweep("clear_sweep_len", 2);
    do_read("clr_10_7", 16'd10, 16'd7, 4'd0);
    do_read("clr_12_12", 16'd12, 16'd12, 4'd0);
    do_read("clr_6_6", 16'd6, 16'd6, 4'd0);
    do_read("clr_3_3", 16'd3, 16'd3, 4'd0);
    do_read("clr_2_2", 16'd2, 16'd2, 4'd4);

    do_write("wr_10_7_again", 16'd10, 16'd7, 4'd1, 1'b1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    rd_en = 1'b1; rd_x = 16'd0; rd_y = 16'd0;
    hsync_in = 1'b1; hcount_in = 16'd0; vcount_in = 16'd0; rgb_in = 12'h5A5;
    repeat (298) @(negedge clk);
    chk("mid_rd_valid", 32'(rd_valid), 32'd1);
    chk("mid_hsync", 32'(hsync_out), 32'd1);
    chk("mid_busy_bg", 32'(rgb_out), 32'h5A5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(init_busy), 32'd1);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_code", 32'(rd_code), 32'd0);
    chk("arst_hsync", 32'(hsync_out), 32'd0);
    chk("arst_rgb", 32'(rgb_out), 32'd0);
    rd_en = 1'b0; hsync_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("rst_sweep_len", 0);
    do_read("fin_2_2", 16'd2, 16'd2, 4'd4);
    do_read("fin_10_7", 16'd10, 16'd7, 4'd0);
    do_read("fin_0_23", 16'd0, 16'd23, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
